proc_io_host: RTL and testbench
===============================

# proc_io_host

Host-side counterpart of the processor I/O port on the float network top. It buffers tagged input samples per channel and answers the processor's one-hot `req_in` read strobes by driving `io_in` from the head of the addressed channel. It captures every `out_en` write strobe together with `io_out` into a tagged output FIFO and drains that FIFO over a valid/ready stream. It sits between the stimulus/DMA logic and the `int2float`/`float2int` boundary of the processor.

## Interface
- `NBIN`, 19, input sample width; matches the processor `io_in`.
- `NBOUT`, 28, output sample width; matches the processor `io_out`.
- `NUIOIN`, 4, number of input channels (width of `req_in`).
- `NUIOOU`, 4, number of output channels (width of `out_en`).
- `IDEPTH`, 4, per-input-channel FIFO depth (power of 2).
- `ODEPTH`, 8, shared output FIFO depth (power of 2).
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `s_valid` in 1: upstream sample valid.
- `s_ready` out 1: upstream may transfer.
- `s_chan` in clog2(NUIOIN): destination input channel.
- `s_data` in NBIN signed: sample.
- `req_in` in NUIOIN: one-hot processor read strobe; 1-cycle pulse.
- `io_in` out NBIN signed: data presented to the processor.
- `out_en` in NUIOOU: one-hot processor write strobe; 1-cycle pulse.
- `io_out` in NBOUT signed: processor output data.
- `m_valid` out 1: output entry available.
- `m_ready` in 1: downstream accepts.
- `m_chan` out clog2(NUIOOU): channel tag of the head entry.
- `m_data` out NBOUT signed: data of the head entry.
- `underrun` out 1: sticky; set when a read hit an empty channel.
- `overflow` out 1: sticky; set when a write was dropped.
- `proto_err` out 1: sticky; set when more than one bit of `req_in` or `out_en` is high.

## Operation
- **Input push.** A push occurs when `s_valid && s_ready`. `s_ready` = !full(`s_chan`), evaluated combinationally; a pop in the same cycle does not free space. The pushed data is visible at the head on the next cycle.
- **Input read.** `io_in` is a combinational mux of the head of the lowest set bit of `req_in`.
  - `io_in` = 0 when `req_in` = 0, or when the selected channel is empty.
  - The head is popped at the edge where `req_in[k]` = 1 and channel k is non-empty.
- **Empty channel read.** The strobe still completes: `io_in` = 0, `underrun` is set, and there is no pop. There is no bypass: with a simultaneous push to the same empty channel, the push lands and the read sees 0.
- **Multiple `req_in` bits.** Only the lowest-index channel is serviced, and `proto_err` is set. The same rule applies to `out_en`: the lowest index is captured and `proto_err` is set.
- **Output capture.** On an `out_en[k]` edge, {k, `io_out`} is written to the output FIFO.
  - The write is accepted if the FIFO is not full, or if the head is popped in the same cycle (`m_valid && m_ready`).
  - Otherwise the entry is dropped and `overflow` is set.
- **Output drain.** The output FIFO is show-ahead. `m_valid` = !empty. `m_chan`/`m_data` are the head entry and hold stable while `m_valid && !m_ready`.
- **Sticky flags.** Cleared only by reset.
- **Arithmetic.** Data passes through bit-exact with no sign conversion. Pointers are clog2(depth)+1 bits, with wrap via the MSB for full/empty.

## Timing
- **Reset values.** `rst`=0 asynchronously empties all FIFOs (pointers to 0) and clears `underrun`/`overflow`/`proto_err`. Outputs during reset: `m_valid`=0, `m_chan`=0, `m_data`=0, `io_in`=0, `s_ready`=1.
- **Latency.**
  - Input push to earliest `req_in` service: 1 cycle.
  - `out_en` to `m_valid`: 1 cycle.
  - `io_in` is combinational from `req_in` (same cycle).
- **Throughput.** One push and one pop per input channel per cycle; one capture and one drain per cycle at the output.
- **Reset mid-operation.** Any in-flight entries are discarded. No strobe is honoured in the reset-release cycle if `rst` is still low at that edge.

## Structure
- **Package `proc_io_pkg`.**
  - Default widths: NBIN, NBOUT, NUIOIN, NUIOOU.
  - A `clog2` function.
  - The output-entry typedef {chan, data}.
- **Sub-module `sync_fifo`.**
  - Parameters: width, depth.
  - Behaviour: show-ahead read, full/empty outputs, async active-low reset.
  - Instantiated NUIOIN times for input (width NBIN) and once for output (width clog2(NUIOOU)+NBOUT).
- **Top level.** Holds the strobe decode (lowest-set-bit priority), the io_in mux and the sticky flags.

## Test plan
- **Per-channel ordering.** Push 5, 7 to channel 2 and -3 to channel 0. Pulse `req_in`=0100, then 0001, then 0100. Required: `io_in` = 5, -3, 7; `underrun`=0.
- **Underrun.** Pulse `req_in`=1000 with channel 3 empty. Required: `io_in`=0 and `underrun`=1 from the next cycle. Then push 9 to channel 3 and read it: `io_in`=9, and `underrun` stays 1.
- **Full input channel.** Fill channel 1 with 4 entries. Required: `s_ready`=0 for `s_chan`=1 while `s_ready`=1 for `s_chan`=0. Pop one entry; `s_ready` for channel 1 returns to 1 the next cycle.
- **Output capture with backpressure.** Hold `m_ready`=0. Issue `out_en`=0010 with `io_out`=0x0ABCDEF, repeated 9 times. Required: 8 entries stored, `overflow`=1, head = {1, 0x0ABCDEF}. Then release `m_ready`: 8 transfers in order.
- **Full FIFO with simultaneous drain.** With the output FIFO full, issue `out_en`=0001 in the same cycle as `m_ready`=1. Required: the entry is accepted and `overflow` stays 0.
- **Protocol error and async reset.** Issue `req_in`=0110. Required: channel 1 is serviced and `proto_err`=1. Then assert `rst`=0 mid-stream. Required: `m_valid`=0, all flags 0, and `io_in`=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/proc_io_pkg.sv
// Shared widths, the clog2 helper and the output-entry type for the processor I/O host.
package proc_io_pkg;

    // Ceiling log2. Returns 0 for values of 1 or less.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result++;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

    localparam int DEFAULT_NBIN   = 19;
    localparam int DEFAULT_NBOUT  = 28;
    localparam int DEFAULT_NUIOIN = 4;
    localparam int DEFAULT_NUIOOU = 4;
    localparam int DEFAULT_IDEPTH = 4;
    localparam int DEFAULT_ODEPTH = 8;

    localparam int CHAN_W = clog2(DEFAULT_NUIOOU);

    // One captured processor write: the channel it came from and its data.
    typedef struct packed {
        logic [CHAN_W-1:0]              chan;
        logic signed [DEFAULT_NBOUT-1:0] data;
    } out_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with full/empty flags and async active-low reset.
module sync_fifo
    import proc_io_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_ok;
    logic             rd_ok;

    // The extra pointer MSB tells a full FIFO apart from an empty one.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A write into a full FIFO is only legal when the head leaves in the same cycle.
    assign wr_ok = wr_en && (!full || rd_en);
    assign rd_ok = rd_en && !empty;

    // The head reads as zero while empty so nothing stale leaks out after reset.
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Pointer update; reset discards all entries by collapsing both pointers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (rd_ok) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage array; contents are don't-care while the slot is not between the pointers.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/proc_io_host.sv
// Host side of the processor I/O port: per-channel input FIFOs, strobe decode and output capture FIFO.
module proc_io_host
    import proc_io_pkg::*;
#(
    parameter int NBIN   = DEFAULT_NBIN,
    parameter int NBOUT  = DEFAULT_NBOUT,
    parameter int NUIOIN = DEFAULT_NUIOIN,
    parameter int NUIOOU = DEFAULT_NUIOOU,
    parameter int IDEPTH = DEFAULT_IDEPTH,
    parameter int ODEPTH = DEFAULT_ODEPTH,
    localparam int IW    = clog2(NUIOIN),
    localparam int OW    = clog2(NUIOOU)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [IW-1:0]           s_chan,
    input  logic signed [NBIN-1:0]  s_data,
    input  logic [NUIOIN-1:0]       req_in,
    output logic signed [NBIN-1:0]  io_in,
    input  logic [NUIOOU-1:0]       out_en,
    input  logic signed [NBOUT-1:0] io_out,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [OW-1:0]           m_chan,
    output logic signed [NBOUT-1:0] m_data,
    output logic                    underrun,
    output logic                    overflow,
    output logic                    proto_err
);

    logic [NUIOIN-1:0] in_full;
    logic [NUIOIN-1:0] in_empty;
    logic [NUIOIN-1:0] in_push;
    logic [NUIOIN-1:0] in_pop;
    logic [NBIN-1:0]   in_head [NUIOIN];

    logic              req_any;
    logic              req_multi;
    logic [IW-1:0]     req_idx;
    logic              cap_any;
    logic              cap_multi;
    logic [OW-1:0]     cap_idx;

    logic              o_full;
    logic              o_empty;
    logic              o_pop;
    logic              o_wr;
    logic [OW+NBOUT-1:0] o_rd_data;

    // Read strobe decode: the lowest set bit wins, more than one set bit is a protocol error.
    always_comb begin
        req_any   = |req_in;
        req_multi = (req_in & (req_in - NUIOIN'(1))) != '0;
        req_idx   = '0;
        for (int i = NUIOIN - 1; i >= 0; i--) begin
            if (req_in[i]) req_idx = IW'(i);
        end
    end

    // Write strobe decode with the same lowest-index priority.
    always_comb begin
        cap_any   = |out_en;
        cap_multi = (out_en & (out_en - NUIOOU'(1))) != '0;
        cap_idx   = '0;
        for (int i = NUIOOU - 1; i >= 0; i--) begin
            if (out_en[i]) cap_idx = OW'(i);
        end
    end

    // Upstream readiness follows the addressed channel only; a same-cycle pop does not count.
    always_comb begin
        s_ready = 1'b1;
        for (int i = 0; i < NUIOIN; i++) begin
            if (s_chan == IW'(i)) s_ready = !in_full[i];
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUIOIN; g++) begin : g_in
            assign in_push[g] = s_valid && s_ready && (s_chan == IW'(g));
            assign in_pop[g]  = req_any && (req_idx == IW'(g)) && !in_empty[g];

            sync_fifo #(
                .WIDTH(NBIN),
                .DEPTH(IDEPTH)
            ) u_in_fifo (
                .clk    (clk),
                .rst    (rst),
                .wr_en  (in_push[g]),
                .wr_data(s_data),
                .rd_en  (in_pop[g]),
                .rd_data(in_head[g]),
                .full   (in_full[g]),
                .empty  (in_empty[g])
            );
        end
    endgenerate

    // An empty channel's head already reads as zero, so no extra gating is needed here.
    assign io_in = req_any ? in_head[req_idx] : '0;

    assign m_valid = !o_empty;
    assign o_pop   = m_valid && m_ready;
    assign o_wr    = cap_any && (!o_full || o_pop);

    sync_fifo #(
        .WIDTH(OW + NBOUT),
        .DEPTH(ODEPTH)
    ) u_out_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (o_wr),
        .wr_data({cap_idx, io_out}),
        .rd_en  (o_pop),
        .rd_data(o_rd_data),
        .full   (o_full),
        .empty  (o_empty)
    );

    assign {m_chan, m_data} = o_rd_data;

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            underrun  <= 1'b0;
            overflow  <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            if (req_any && in_empty[req_idx]) underrun <= 1'b1;
            if (cap_any && o_full && !o_pop)  overflow <= 1'b1;
            if (req_multi || cap_multi)       proto_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_proc_io_host.sv
// Self-checking bench for proc_io_host against a queue-based behavioural model.
module tb_proc_io_host;
    import proc_io_pkg::*;

    localparam int NBIN   = DEFAULT_NBIN;
    localparam int NBOUT  = DEFAULT_NBOUT;
    localparam int NUIOIN = DEFAULT_NUIOIN;
    localparam int NUIOOU = DEFAULT_NUIOOU;
    localparam int IDEPTH = DEFAULT_IDEPTH;
    localparam int ODEPTH = DEFAULT_ODEPTH;
    localparam int IW     = clog2(NUIOIN);
    localparam int OW     = clog2(NUIOOU);

    logic                    clk;
    logic                    rst;
    logic                    s_valid;
    logic                    s_ready;
    logic [IW-1:0]           s_chan;
    logic signed [NBIN-1:0]  s_data;
    logic [NUIOIN-1:0]       req_in;
    logic signed [NBIN-1:0]  io_in;
    logic [NUIOOU-1:0]       out_en;
    logic signed [NBOUT-1:0] io_out;
    logic                    m_valid;
    logic                    m_ready;
    logic [OW-1:0]           m_chan;
    logic signed [NBOUT-1:0] m_data;
    logic                    underrun;
    logic                    overflow;
    logic                    proto_err;

    int checks;
    int failures;

    // Behavioural model: one queue per input channel, one queue for the output stream.
    logic signed [NBIN-1:0] iq [NUIOIN][$];
    out_entry_t             oq [$];
    logic                   mod_under;
    logic                   mod_over;
    logic                   mod_proto;

    proc_io_host dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_chan   (s_chan),
        .s_data   (s_data),
        .req_in   (req_in),
        .io_in    (io_in),
        .out_en   (out_en),
        .io_out   (io_out),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_chan   (m_chan),
        .m_data   (m_data),
        .underrun (underrun),
        .overflow (overflow),
        .proto_err(proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lowest(input logic [NUIOIN-1:0] v);
        for (int i = 0; i < NUIOIN; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic signed [NBIN-1:0] exp_io_in();
        int k;
        k = lowest(req_in);
        if (k < 0) return '0;
        if (iq[k].size() == 0) return '0;
        return iq[k][0];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUIOIN; i++) iq[i].delete();
        oq.delete();
        mod_under = 1'b0;
        mod_over  = 1'b0;
        mod_proto = 1'b0;
    endtask

    task automatic drive_idle();
        s_valid = 1'b0;
        s_chan  = '0;
        s_data  = '0;
        req_in  = '0;
        out_en  = '0;
        io_out  = '0;
        m_ready = 1'b0;
    endtask

    // Advance the model by the inputs currently driven, then clock the DUT.
    task automatic tick();
        int         k;
        int         kc;
        bit         push_ok;
        bit         opop;
        out_entry_t e;
        push_ok = s_valid && (iq[s_chan].size() < IDEPTH);
        k = lowest(req_in);
        if (k >= 0) begin
            if (iq[k].size() == 0) mod_under = 1'b1;
            else void'(iq[k].pop_front());
        end
        if (push_ok) iq[s_chan].push_back(s_data);
        if ($countones(req_in) > 1 || $countones(out_en) > 1) mod_proto = 1'b1;
        kc   = lowest(out_en);
        opop = (oq.size() > 0) && m_ready;
        if (opop) void'(oq.pop_front());
        if (kc >= 0) begin
            if (opop || oq.size() < ODEPTH) begin
                e.chan = OW'(kc);
                e.data = io_out;
                oq.push_back(e);
            end else begin
                mod_over = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_sample(input int ch, input int val);
        s_valid = 1'b1;
        s_chan  = IW'(ch);
        s_data  = NBIN'(val);
        tick();
        s_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive_idle();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive_idle();
        model_reset();
        #3;
        checks++;
        if (m_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_m_valid: got %b expected 0", m_valid); end
        checks++;
        if (m_chan !== '0 || m_data !== '0) begin failures++; $display("[TB] FAIL reset_m_head: got chan %0d data %0h expected 0/0", m_chan, m_data); end
        checks++;
        if (io_in !== '0) begin failures++; $display("[TB] FAIL reset_io_in: got %0d expected 0", io_in); end
        checks++;
        if (s_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_s_ready: got %b expected 1", s_ready); end
        checks++;
        if ({underrun, overflow, proto_err} !== 3'b000) begin failures++; $display("[TB] FAIL reset_flags: got %b expected 000", {underrun, overflow, proto_err}); end
        @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    task automatic test_ordering();
        logic [NUIOIN-1:0]      pats [3];
        logic signed [NBIN-1:0] want [3];
        pats = '{4'b0100, 4'b0001, 4'b0100};
        want = '{19'sd5, -19'sd3, 19'sd7};
        push_sample(2, 5);
        push_sample(2, 7);
        push_sample(0, -3);
        for (int i = 0; i < 3; i++) begin
            req_in = pats[i];
            #1;
            checks++;
            if (io_in !== want[i]) begin failures++; $display("[TB] FAIL ordering_io_in[%0d]: got %0d expected %0d", i, io_in, want[i]); end
            tick();
            req_in = '0;
        end
        checks++;
        if (underrun !== 1'b0) begin failures++; $display("[TB] FAIL ordering_underrun: got %b expected 0", underrun); end
    endtask

    task automatic test_underrun();
        req_in = 4'b1000;
        #1;
        checks++;
        if (io_in !== '0) begin failures++; $display("[TB] FAIL underrun_io_in: got %0d expected 0", io_in); end
        tick();
        req_in = '0;
        checks++;
        if (underrun !== 1'b1) begin failures++; $display("[TB] FAIL underrun_flag: got %b expected 1", underrun); end
        push_sample(3, 9);
        req_in = 4'b1000;
        #1;
        checks++;
        if (io_in !== 19'sd9) begin failures++; $display("[TB] FAIL underrun_refill_io_in: got %0d expected 9", io_in); end
        tick();
        req_in = '0;
        checks++;
        if (underrun !== 1'b1) begin failures++; $display("[TB] FAIL underrun_sticky: got %b expected 1", underrun); end
    endtask

    task automatic test_full_input();
        logic signed [NBIN-1:0] exp;
        for (int i = 0; i < IDEPTH; i++) push_sample(1, 100 + i);
        s_chan = IW'(1);
        #1;
        checks++;
        if (s_ready !== 1'b0) begin failures++; $display("[TB] FAIL full_s_ready_ch1: got %b expected 0", s_ready); end
        s_chan = IW'(0);
        #1;
        checks++;
        if (s_ready !== 1'b1) begin failures++; $display("[TB] FAIL full_s_ready_ch0: got %b expected 1", s_ready); end
        s_chan  = IW'(1);
        s_valid = 1'b1;
        s_data  = 19'sd99;
        req_in  = 4'b0010;
        #1;
        checks++;
        if (s_ready !== 1'b0) begin failures++; $display("[TB] FAIL full_pop_no_free: got %b expected 0", s_ready); end
        checks++;
        if (io_in !== 19'sd100) begin failures++; $display("[TB] FAIL full_head: got %0d expected 100", io_in); end
        tick();
        s_valid = 1'b0;
        req_in  = '0;
        #1;
        checks++;
        if (s_ready !== 1'b1) begin failures++; $display("[TB] FAIL full_s_ready_after_pop: got %b expected 1", s_ready); end
        while (iq[1].size() > 0) begin
            req_in = 4'b0010;
            #1;
            exp = exp_io_in();
            checks++;
            if (io_in !== exp) begin failures++; $display("[TB] FAIL full_drain_io_in: got %0d expected %0d", io_in, exp); end
            tick();
        end
        req_in = '0;
    endtask

    task automatic test_full_drain();
        m_ready = 1'b0;
        out_en  = 4'b0100;
        for (int i = 0; i < ODEPTH; i++) begin
            io_out = NBOUT'($urandom);
            tick();
        end
        out_en  = 4'b0001;
        io_out  = 28'sh1234567;
        m_ready = 1'b1;
        tick();
        out_en = '0;
        checks++;
        if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL drain_overflow: got %b expected 0", overflow); end
        for (int i = 0; i < ODEPTH; i++) begin
            #1;
            checks++;
            if (m_valid !== 1'b1 || m_chan !== oq[0].chan || m_data !== oq[0].data) begin
                failures++;
                $display("[TB] FAIL drain_entry[%0d]: got v=%b chan %0d data %0h expected v=1 chan %0d data %0h", i, m_valid, m_chan, m_data, oq[0].chan, oq[0].data);
            end
            tick();
        end
        checks++;
        if (m_valid !== 1'b0) begin failures++; $display("[TB] FAIL drain_empty: got %b expected 0", m_valid); end
        m_ready = 1'b0;
    endtask

    task automatic test_output_backpressure();
        m_ready = 1'b0;
        out_en  = 4'b0010;
        io_out  = 28'sh0ABCDEF;
        repeat (ODEPTH + 1) tick();
        out_en = '0;
        #1;
        checks++;
        if (overflow !== 1'b1) begin failures++; $display("[TB] FAIL bp_overflow: got %b expected 1", overflow); end
        checks++;
        if (m_valid !== 1'b1 || m_chan !== 2'd1 || m_data !== 28'sh0ABCDEF) begin
            failures++;
            $display("[TB] FAIL bp_head: got v=%b chan %0d data %0h expected v=1 chan 1 data abcdef", m_valid, m_chan, m_data);
        end
        m_ready = 1'b1;
        for (int i = 0; i < ODEPTH; i++) begin
            #1;
            checks++;
            if (m_valid !== 1'b1 || m_chan !== 2'd1 || m_data !== 28'sh0ABCDEF) begin
                failures++;
                $display("[TB] FAIL bp_transfer[%0d]: got v=%b chan %0d data %0h", i, m_valid, m_chan, m_data);
            end
            tick();
        end
        checks++;
        if (m_valid !== 1'b0) begin failures++; $display("[TB] FAIL bp_count: got m_valid %b expected 0 after 8 transfers", m_valid); end
        m_ready = 1'b0;
    endtask

    task automatic test_random();
        int                     r;
        logic signed [NBIN-1:0] exp_io;
        for (int n = 0; n < 400; n++) begin
            s_valid = 1'($urandom_range(0, 1));
            s_chan  = IW'($urandom);
            s_data  = NBIN'($urandom);
            r = $urandom_range(0, 7);
            req_in  = (r < 4) ? NUIOIN'(1 << r) : ((r == 7) ? NUIOIN'($urandom) : '0);
            r = $urandom_range(0, 7);
            out_en  = (r < 4) ? NUIOOU'(1 << r) : ((r == 7) ? NUIOOU'($urandom) : '0);
            io_out  = NBOUT'($urandom);
            m_ready = 1'($urandom_range(0, 1));
            #1;
            exp_io = exp_io_in();
            checks++;
            if (io_in !== exp_io) begin failures++; $display("[TB] FAIL rand_io_in[%0d]: got %0d expected %0d", n, io_in, exp_io); end
            checks++;
            if (s_ready !== (iq[s_chan].size() < IDEPTH)) begin failures++; $display("[TB] FAIL rand_s_ready[%0d]: got %b", n, s_ready); end
            checks++;
            if (m_valid !== (oq.size() > 0)) begin failures++; $display("[TB] FAIL rand_m_valid[%0d]: got %b expected %0d", n, m_valid, oq.size() > 0); end
            if (oq.size() > 0) begin
                checks++;
                if (m_chan !== oq[0].chan || m_data !== oq[0].data) begin
                    failures++;
                    $display("[TB] FAIL rand_m_head[%0d]: got chan %0d data %0h expected chan %0d data %0h", n, m_chan, m_data, oq[0].chan, oq[0].data);
                end
            end
            tick();
            checks++;
            if ({underrun, overflow, proto_err} !== {mod_under, mod_over, mod_proto}) begin
                failures++;
                $display("[TB] FAIL rand_flags[%0d]: got %b expected %b", n, {underrun, overflow, proto_err}, {mod_under, mod_over, mod_proto});
            end
        end
        drive_idle();
    endtask

    task automatic test_proto_reset();
        do_reset();
        push_sample(1, 11);
        push_sample(1, 12);
        push_sample(2, 13);
        out_en = 4'b0010;
        io_out = 28'sd77;
        tick();
        out_en = '0;
        req_in = 4'b0110;
        #1;
        checks++;
        if (io_in !== 19'sd11) begin failures++; $display("[TB] FAIL proto_io_in: got %0d expected 11", io_in); end
        tick();
        req_in = '0;
        checks++;
        if (proto_err !== 1'b1 || underrun !== 1'b0) begin failures++; $display("[TB] FAIL proto_flags: got proto %b under %b expected 1/0", proto_err, underrun); end
        s_chan = IW'(1);
        req_in = 4'b0010;
        #1;
        checks++;
        if (io_in !== 19'sd12 || m_valid !== 1'b1) begin failures++; $display("[TB] FAIL proto_pre_reset: got io_in %0d m_valid %b expected 12/1", io_in, m_valid); end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (io_in !== '0) begin failures++; $display("[TB] FAIL async_io_in: got %0d expected 0", io_in); end
        checks++;
        if (m_valid !== 1'b0 || m_data !== '0) begin failures++; $display("[TB] FAIL async_m_valid: got v=%b data %0h expected 0/0", m_valid, m_data); end
        checks++;
        if ({underrun, overflow, proto_err} !== 3'b000) begin failures++; $display("[TB] FAIL async_flags: got %b expected 000", {underrun, overflow, proto_err}); end
        checks++;
        if (s_ready !== 1'b1) begin failures++; $display("[TB] FAIL async_s_ready: got %b expected 1", s_ready); end
        drive_idle();
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        push_sample(1, 21);
        req_in = 4'b0010;
        #1;
        checks++;
        if (io_in !== 19'sd21) begin failures++; $display("[TB] FAIL post_reset_io_in: got %0d expected 21", io_in); end
        tick();
        req_in = '0;
    endtask

    // Runs every scenario in order and prints the summary line.
    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_ordering();
        test_underrun();
        test_full_input();
        test_full_drain();
        test_output_backpressure();
        test_random();
        test_proto_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
